// File: rtl/relu_maxpool.sv
// relu_maxpool
// Optional ReLU followed by a 2x2, stride-2 max-pool over one M x M frame of
// convolution results arriving in raster order. A running horizontal maximum
// is formed on each odd column. On even rows it is parked in a half-width line
// buffer. On odd rows it is combined with the parked value to give one pooled
// result.
//
// Ports:
//   clk        in   rising-edge clock
//   global_rst in   asynchronous active-high reset
//   ce         in   clock enable; low freezes all state
//   conv_in    in   [N-1:0] signed sample, raster order
//   valid_in   in   conv_in is valid this cycle
//   pool_out   out  [N-1:0] pooled maximum; holds when valid_out is low
//   valid_out  out  one-cycle pulse, one clock after the accepting edge
//   end_pool   out  level, set by the last sample of the frame; cleared by reset
module relu_maxpool #(
  parameter int M    = 8,
  parameter int N    = 16,
  parameter int RELU = 1
) (
  input  logic         clk,
  input  logic         global_rst,
  input  logic         ce,
  input  logic [N-1:0] conv_in,
  input  logic         valid_in,
  output logic [N-1:0] pool_out,
  output logic         valid_out,
  output logic         end_pool
);

  localparam int CW      = $clog2(M);
  localparam int HALF    = M / 2;
  localparam int LB_AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int LB_SIZE = 1 << LB_AW;
  // Rows/columns below PW take part in pooling; for odd M the last one is dropped.
  localparam logic [CW:0]   PW_L = (CW + 1)'(2 * HALF);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic [N-1:0]  r_h;
  logic [N-1:0]  r_linebuf [LB_SIZE];
  logic [N-1:0]  r_pool;
  logic          r_valid;
  logic          r_end;

  logic             w_accept;
  logic [N-1:0]     w_sample;
  logic             w_in_pool;
  logic             w_odd_col;
  logic             w_odd_row;
  logic             w_last;
  logic [LB_AW-1:0] w_lb_idx;
  logic [N-1:0]     w_lb_rd;
  logic [N-1:0]     w_hmax;
  logic [N-1:0]     w_vmax;

  assign w_accept  = ce & valid_in & ~r_end;
  assign w_odd_col = r_col[0];
  assign w_odd_row = r_row[0];
  assign w_in_pool = ({1'b0, r_col} < PW_L) && ({1'b0, r_row} < PW_L);
  assign w_last    = (r_col == LAST) && (r_row == LAST);
  assign w_lb_idx  = LB_AW'(r_col >> 1);
  assign w_lb_rd   = r_linebuf[w_lb_idx];

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sample = conv_in;
    if ((RELU != 0) && conv_in[N-1]) begin
      w_sample = '0;
    end
  end

  // Ties may take either operand; the values are equal.
  assign w_hmax = ($signed(r_h) > $signed(w_sample)) ? r_h : w_sample;
  assign w_vmax = ($signed(w_lb_rd) > $signed(w_hmax)) ? w_lb_rd : w_hmax;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_h     <= '0;
      r_pool  <= '0;
      r_valid <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      // The pulse drops every cycle, including those with ce low.
      r_valid <= 1'b0;
      if (w_accept) begin
        if (r_col == LAST) begin
          r_col <= '0;
          r_row <= (r_row == LAST) ? '0 : r_row + CW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end

        if (w_in_pool) begin
          if (!w_odd_col) begin
            r_h <= w_sample;
          end else if (w_odd_row) begin
            r_pool  <= w_vmax;
            r_valid <= 1'b1;
          end
        end

        if (w_last) begin
          r_end <= 1'b1;
        end
      end
    end
  end

  // NOTE: the line buffer is deliberately left out of reset. Every entry is
  // written on an even row before the following odd row reads it.
  always_ff @(posedge clk) begin
    if (w_accept && w_in_pool && w_odd_col && !w_odd_row) begin
      r_linebuf[w_lb_idx] <= w_hmax;
    end
  end

  assign pool_out  = r_pool;
  assign valid_out = r_valid;
  assign end_pool  = r_end;

endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench for relu_maxpool. Three instances are used:
//   dut 0: M=4, RELU=1
//   dut 1: M=4, RELU=0
//   dut 2: M=5, RELU=1
// Stimulus pushes hand-computed results into a per-instance queue. A negedge
// monitor pops an entry and compares it on every valid_out pulse.
module tb_relu_maxpool;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0] din  [3];
  logic         vin  [3];
  logic         ce_s [3];
  logic [N-1:0] pool [3];
  logic         vout [3];
  logic         endp [3];

  relu_maxpool #(.M(4), .N(N), .RELU(1)) dut0 (
    .clk(clk), .global_rst(rst), .ce(ce_s[0]), .conv_in(din[0]), .valid_in(vin[0]),
    .pool_out(pool[0]), .valid_out(vout[0]), .end_pool(endp[0])
  );
  relu_maxpool #(.M(4), .N(N), .RELU(0)) dut1 (
    .clk(clk), .global_rst(rst), .ce(ce_s[1]), .conv_in(din[1]), .valid_in(vin[1]),
    .pool_out(pool[1]), .valid_out(vout[1]), .end_pool(endp[1])
  );
  relu_maxpool #(.M(5), .N(N), .RELU(1)) dut2 (
    .clk(clk), .global_rst(rst), .ce(ce_s[2]), .conv_in(din[2]), .valid_in(vin[2]),
    .pool_out(pool[2]), .valid_out(vout[2]), .end_pool(endp[2])
  );

  logic [N-1:0] q0 [$];
  logic [N-1:0] q1 [$];
  logic [N-1:0] q2 [$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon(input int d);
    logic [N-1:0] e;
    bit           have;
    have = 1'b0;
    e    = '0;
    case (d)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (have) begin
      check($sformatf("pool_out_dut%0d", d), 32'(pool[d]), 32'(e));
    end else begin
      n_assert++;
      n_fail++;
      $display("FAIL unexpected_pulse_dut%0d: got pool_out 0x%0h, expected no pulse", d, pool[d]);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (vout[d] === 1'b1) mon(d);
    end
  end

  task automatic send(input int d, input logic [N-1:0] v);
    din[d]  = v;
    vin[d]  = 1'b1;
    ce_s[d] = 1'b1;
    @(negedge clk);
    vin[d]  = 1'b0;
    din[d]  = '0;
  endtask

  // Idle cycles: either ce low with garbage offered, or ce high with valid_in low.
  task automatic gap(input int d, input int cycles);
    bit mode;
    for (int k = 0; k < cycles; k++) begin
      mode   = 1'($urandom_range(0, 1));
      din[d] = 16'h7FFF;
      if (mode) begin
        ce_s[d] = 1'b0;
        vin[d]  = 1'b1;
      end else begin
        ce_s[d] = 1'b1;
        vin[d]  = 1'b0;
      end
      @(negedge clk);
      if (mode) check("ce_low_no_pulse", 32'(vout[d]), 32'd0);
      ce_s[d] = 1'b1;
      vin[d]  = 1'b0;
      din[d]  = '0;
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [N-1:0] mix [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mix = '{16'hFFF8, 16'h0002, 16'hFFFF, 16'hFFF7,
            16'h0003, 16'hFFFC, 16'hFFFE, 16'hFFFB,
            16'hFFF9, 16'hFFFA, 16'h000A, 16'hFF9C,
            16'hFFEC, 16'hFFE2, 16'hFFFF, 16'hFFFE};
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      din[d]  = '0;
      vin[d]  = 1'b0;
      ce_s[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_pool_dut%0d", d), 32'(pool[d]), 32'd0);
      check($sformatf("reset_valid_dut%0d", d), 32'(vout[d]), 32'd0);
      check($sformatf("reset_end_dut%0d", d), 32'(endp[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Ramp 0..15 on M=4, and ramp 0..24 on M=5 (odd M drops the last row and column).
    q0.push_back(16'd5); q0.push_back(16'd7); q0.push_back(16'd13); q0.push_back(16'd15);
    for (int i = 0; i < 16; i++) begin
      send(0, 16'(i));
      if (i == 14) check("end_pool_before_last_m4", 32'(endp[0]), 32'd0);
    end
    check("end_pool_last_m4", 32'(endp[0]), 32'd1);
    check("valid_with_end_m4", 32'(vout[0]), 32'd1);

    q2.push_back(16'd6); q2.push_back(16'd8); q2.push_back(16'd16); q2.push_back(16'd18);
    for (int i = 0; i < 25; i++) begin
      send(2, 16'(i));
      if (i == 23) check("end_pool_before_last_m5", 32'(endp[2]), 32'd0);
    end
    check("end_pool_last_m5", 32'(endp[2]), 32'd1);
    check("no_valid_last_m5", 32'(vout[2]), 32'd0);

    // All -3: zero after ReLU, unchanged when bypassed.
    do_reset();
    for (int k = 0; k < 4; k++) q0.push_back(16'h0000);
    for (int i = 0; i < 16; i++) send(0, 16'hFFFD);
    for (int k = 0; k < 4; k++) q1.push_back(16'hFFFD);
    for (int i = 0; i < 16; i++) send(1, 16'hFFFD);

    // Mixed signs must compare as signed values; ramp with random gaps.
    do_reset();
    q1.push_back(16'h0003); q1.push_back(16'hFFFF); q1.push_back(16'hFFFA); q1.push_back(16'h000A);
    for (int i = 0; i < 16; i++) send(1, mix[i]);
    q0.push_back(16'd5); q0.push_back(16'd7); q0.push_back(16'd13); q0.push_back(16'd15);
    for (int i = 0; i < 16; i++) begin
      gap(0, int'($urandom_range(0, 3)));
      send(0, 16'(i));
    end
    check("end_pool_gapped", 32'(endp[0]), 32'd1);

    // Mid-frame reset, fresh frame, then extra input after end_pool.
    do_reset();
    q0.push_back(16'd5);
    for (int i = 0; i < 6; i++) send(0, 16'(i));
    #2 rst = 1'b1;
    #1;
    check("async_reset_pool", 32'(pool[0]), 32'd0);
    check("async_reset_end", 32'(endp[0]), 32'd0);
    check("async_reset_valid", 32'(vout[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q0.push_back(16'd5); q0.push_back(16'd7); q0.push_back(16'd13); q0.push_back(16'd15);
    for (int i = 0; i < 16; i++) send(0, 16'(i));
    for (int i = 0; i < 4; i++) send(0, 16'h0064);
    check("end_pool_sticky", 32'(endp[0]), 32'd1);
    check("pool_out_hold", 32'(pool[0]), 32'd15);

    repeat (3) @(negedge clk);
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);
    check("drain_q2", 32'(q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_maxpool.md
RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 Parameter M, default 8: side length of the square convolution output map received per frame (M >= 2).
REQ-002 Parameter N, default 16: sample bit width, signed two's complement.
REQ-003 Parameter RELU, default 1: 1 applies ReLU before pooling; 0 bypasses ReLU.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 global_rst  input  1  reset; asynchronous, active-high.
REQ-006 ce  input  1  clock enable; when low, no sample is accepted and all state is frozen.
REQ-007 conv_in  input  N  convolution result sample, raster order (row-major).
REQ-008 valid_in  input  1  conv_in holds a valid sample this cycle.
REQ-009 pool_out  output  N  2x2 stride-2 max-pool result.
REQ-010 valid_out  output  1  one-cycle pulse: pool_out is valid.
REQ-011 end_pool  output  1  level: the full frame has been pooled.

Function
REQ-012 A sample is accepted on a rising edge where ce=1, valid_in=1 and end_pool=0; no other cycle changes counters, buffers or outputs except as stated in REQ-021.
REQ-013 ReLU: when RELU=1, an accepted sample with its MSB set is replaced by 0; otherwise it passes unchanged.
REQ-014 Column counter col (0..M-1) and row counter row (0..M-1) index the accepted sample; col increments per accepted sample, wraps to 0 after M-1 and then row increments.
REQ-015 Even col (bit0=0): the post-ReLU sample is stored in horizontal register h_reg.
REQ-016 Odd col: hmax = signed max(h_reg, sample); all comparisons are signed N-bit, with ties taking either operand (values are equal).
REQ-017 Odd col, even row: hmax is written to line buffer entry col>>1 (depth M/2, width N); no output.
REQ-018 Odd col, odd row: pool_out <= signed max(linebuf[col>>1], hmax) and valid_out=1 on the next cycle (latency 1 clock from the accepting edge).
REQ-019 Odd M: the sample at col=M-1 is accepted (counters advance) but discarded; all samples of row M-1 are accepted but produce no writes or outputs.
REQ-020 Outputs per frame: exactly floor(M/2)^2 valid_out pulses, in raster order of the pooled map.
REQ-021 valid_out is high for exactly one cycle per result; it is 0 in every cycle not immediately following an output-producing acceptance, including when ce is low.
REQ-022 pool_out holds its last value when valid_out=0.
REQ-023 end_pool goes high on the edge that accepts sample (row=M-1, col=M-1), i.e. in the same cycle as the final valid_out pulse for even M, and stays high until reset.
REQ-024 While end_pool=1, valid_in is ignored (no new frame is started without reset).
REQ-025 Line buffer entries are overwritten each even row; their contents are not reset and are never read before being written within a frame.

Reset
REQ-026 On global_rst assertion, asynchronously: col=0, row=0, h_reg=0, pool_out=0, valid_out=0, end_pool=0.
REQ-027 Reset asserted mid-frame discards all partial results; the first accepted sample after release is treated as (row 0, col 0).
REQ-028 No acceptance occurs on any edge while global_rst is high.

Verification
REQ-029 M=4, RELU=1, ce=1, conv_in=0..15 raster with valid_in continuous -> valid_out pulses with pool_out 5, 7, 13, 15; end_pool high from the last pulse onward.
REQ-030 M=4, RELU=1, all inputs -3 -> four outputs of 0; same stimulus with RELU=0 -> four outputs of -3 (16'hFFFD).
REQ-031 M=4, RELU=0, mixed signs {-8,2,-1,-9 / 3,-4,-2,-5 / ...} -> first outputs 3 and -1 (signed comparison, not unsigned).
REQ-032 M=5, RELU=1, conv_in=0..24 -> exactly four outputs 6, 8, 16, 18; end_pool high after sample 24 accepted, no output for row 4 or col 4.
REQ-033 M=4, valid_in and ce toggled randomly (gaps of 0-3 cycles) with the data of REQ-029 -> identical output sequence; no valid_out while ce=0.
REQ-034 Reset asserted after 6 samples of a frame, then a full fresh 0..15 frame -> outputs 5, 7, 13, 15 only; extra valid_in after end_pool produces no pulses.
